// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes, debounces and edge-detects active-low push buttons,
// and generates an auto-repeat pulse train while a key stays held.
module key_conditioner #(
  parameter int NKEYS = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NKEYS-1:0] key_n,
  output logic [NKEYS-1:0] level,
  output logic [NKEYS-1:0] press,
  output logic [NKEYS-1:0] rel,
  output logic [NKEYS-1:0] rpt
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rstate_t;
  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    logic s1, s2, lv, pr, rl, rp, done;
    logic [DW-1:0] dcnt;
    logic [RW-1:0] rcnt;
    rstate_t st;
    assign done = (s2 != lv) && (dcnt == DW'(DEBOUNCE_CYCLES - 1));
    assign level[i] = lv;
    assign press[i] = pr;
    assign rel[i] = rl;
    assign rpt[i] = rp;
    // Synchronizer resets to the released state so leaving reset never looks like a press.
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
        dcnt <= '0;
        lv <= 1'b0;
        pr <= 1'b0;
        rl <= 1'b0;
      end else begin
        s1 <= ~key_n[i];
        s2 <= s1;
        dcnt <= (s2 == lv || done) ? '0 : dcnt + 1'b1;
        if (done) lv <= s2;
        pr <= done && s2;
        rl <= done && !s2;
      end
    // Repeat timing starts on the same edge that registers the press pulse.
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        st <= IDLE;
        rcnt <= '0;
        rp <= 1'b0;
      end else begin
        rp <= 1'b0;
        if (done) begin
          st <= s2 ? DELAY : IDLE;
          rcnt <= '0;
        end else if (st == DELAY) begin
          if (rcnt == RW'(REPEAT_DELAY - 1)) begin
            rp <= 1'b1;
            rcnt <= '0;
            st <= REPEAT;
          end else rcnt <= rcnt + 1'b1;
        end else if (st == REPEAT) begin
          if (rcnt == RW'(REPEAT_PERIOD - 1)) begin
            rp <= 1'b1;
            rcnt <= '0;
          end else rcnt <= rcnt + 1'b1;
        end
      end
  end
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed table, corner sequences and random stimulus against a window-based model.
module tb_key_conditioner;
  localparam int NK = 3, D = 4, RD = 10, RP = 3;
  logic clk = 0;
  logic reset = 1;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] level, press, rel, rpt;
  int vectors = 0, errs = 0;
  key_conditioner #(.NKEYS(NK), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .level(level), .press(press), .rel(rel), .rpt(rpt)
  );
  always #5 clk = ~clk;
  // Model: a level is accepted once the last D synchronized samples all disagree with it.
  bit rawq[NK][$];
  bit winq[NK][$];
  bit mlvl[NK], held[NK];
  int pt[NK];
  int t = 0;
  logic [NK-1:0] el = '0, ep = '0, er = '0, erp = '0;
  always @(posedge clk) begin
    bit s, acc;
    t++;
    for (int i = 0; i < NK; i++) begin
      ep[i] = 0;
      er[i] = 0;
      erp[i] = 0;
      if (reset) begin
        rawq[i] = {1'b0, 1'b0};
        winq[i].delete();
        mlvl[i] = 0;
        held[i] = 0;
      end else begin
        rawq[i].push_back(~key_n[i]);
        s = rawq[i].pop_front();
        winq[i].push_back(s);
        if (winq[i].size() > D) void'(winq[i].pop_front());
        acc = (winq[i].size() == D);
        for (int k = 0; k < winq[i].size(); k++) if (winq[i][k] == mlvl[i]) acc = 0;
        if (acc) begin
          mlvl[i] = s;
          winq[i].delete();
          if (s) begin
            ep[i] = 1;
            held[i] = 1;
            pt[i] = t;
          end else begin
            er[i] = 1;
            held[i] = 0;
          end
        end else if (held[i] && t - pt[i] >= RD && (t - pt[i] - RD) % RP == 0) erp[i] = 1;
      end
      el[i] = mlvl[i];
    end
  end
  always @(negedge clk) begin
    vectors++;
    if ({level, press, rel, rpt} !== {el, ep, er, erp}) begin
      errs++;
      $display("FAIL model t=%0d got lvl/prs/rel/rpt=%b/%b/%b/%b want %b/%b/%b/%b",
               t, level, press, rel, rpt, el, ep, er, erp);
    end
  end
  typedef struct {
    logic [NK-1:0] kn;
    int cyc;
    logic [NK-1:0] lvl;
    int np, nr, nrpt;
  } step_t;
  step_t steps[9];
  task automatic check(string name, int got, int want);
    vectors++;
    if (got != want) begin
      errs++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask
  initial begin
    int np, nr, nrp, k;
    steps = '{
      '{3'b111, 50, 3'b000, 0, 0, 0},
      '{3'b101, 5, 3'b000, 0, 0, 0},
      '{3'b101, 1, 3'b010, 1, 0, 0},
      '{3'b101, 22, 3'b010, 0, 0, 5},
      '{3'b111, 5, 3'b010, 0, 0, 1},
      '{3'b111, 1, 3'b000, 0, 1, 0},
      '{3'b111, 20, 3'b000, 0, 0, 0},
      '{3'b100, 6, 3'b011, 2, 0, 0},
      '{3'b111, 12, 3'b000, 0, 2, 0}
    };
    repeat (3) @(negedge clk);
    reset = 0;
    for (int s = 0; s < 9; s++) begin
      key_n = steps[s].kn;
      np = 0; nr = 0; nrp = 0;
      repeat (steps[s].cyc) begin
        @(negedge clk);
        np += $countones(press);
        nr += $countones(rel);
        nrp += $countones(rpt);
      end
      check($sformatf("step%0d_level", s), int'(level), int'(steps[s].lvl));
      check($sformatf("step%0d_press", s), np, steps[s].np);
      check($sformatf("step%0d_release", s), nr, steps[s].nr);
      check($sformatf("step%0d_rpt", s), nrp, steps[s].nrpt);
    end
    np = 0;
    for (int c = 0; c < 10; c++) begin
      key_n[0] = 0;
      repeat (3) begin @(negedge clk); np += int'(press[0]); end
      key_n[0] = 1;
      @(negedge clk);
      np += int'(press[0]);
    end
    check("bounce_no_press", np, 0);
    key_n[0] = 0;
    k = 0;
    do begin @(negedge clk); k++; end while (!press[0] && k < 20);
    check("bounce_press_latency", k, 6);
    key_n = '1;
    repeat (12) @(negedge clk);
    key_n[2] = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("reset_level2", int'(level[2]), 0);
    @(negedge clk);
    reset = 0;
    k = 0;
    do begin @(negedge clk); k++; end while (!press[2] && k < 20);
    check("reset_press_latency", k, 6);
    key_n = '1;
    repeat (12) @(negedge clk);
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) key_n = 3'($urandom);
      else key_n = key_n ^ (3'b001 << $urandom_range(0, 2));
      if ($urandom_range(0, 29) == 0) reset = 1;
      repeat ($urandom_range(1, 14)) begin
        @(negedge clk);
        reset = 0;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
